// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with byte-wide memory, pointer auto-increment and write strobe.
// Define I2C_SLAVE_MEM_GLITCH_FILT_EN to add a 3-sample majority filter on scl/sda.
module i2c_slave_mem #(
    parameter logic [6:0] CHIP_ADDR = 7'h18,
    parameter int         DEPTH     = 256,
    parameter int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          scl,
    inout  wire           sda,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACK_A  = 3'd2;
    localparam logic [2:0] S_RX_PTR = 3'd3;
    localparam logic [2:0] S_RX_DAT = 3'd4;
    localparam logic [2:0] S_ACK_R  = 3'd5;
    localparam logic [2:0] S_TX     = 3'd6;
    localparam logic [2:0] S_RX_ACK = 3'd7;

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_c, sda_c, scl_p_q, sda_p_q;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sreg_q, sreg_d, txb_q, txb_d;
    logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d, rd_byte;
    logic          sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d, mem_we;
    logic [7:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

`ifdef I2C_SLAVE_MEM_GLITCH_FILT_EN
    logic [2:0] scl_f_q, sda_f_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_f_q <= 3'b111;
            sda_f_q <= 3'b111;
        end else begin
            scl_f_q <= {scl_f_q[1:0], scl_sync_q[1]};
            sda_f_q <= {sda_f_q[1:0], sda_sync_q[1]};
        end
    end
    assign scl_c = (scl_f_q[0] & scl_f_q[1]) | (scl_f_q[0] & scl_f_q[2])
                 | (scl_f_q[1] & scl_f_q[2]);
    assign sda_c = (sda_f_q[0] & sda_f_q[1]) | (sda_f_q[0] & sda_f_q[2])
                 | (sda_f_q[1] & sda_f_q[2]);
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    assign scl_rise  = !scl_p_q && scl_c;
    assign scl_fall  = scl_p_q && !scl_c;
    assign start_det = scl_p_q && scl_c && sda_p_q && !sda_c;
    assign stop_det  = scl_p_q && scl_c && !sda_p_q && sda_c;
    assign rd_byte   = mem[ptr_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        txb_d     = txb_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        // Bus conditions override whatever the bit engine would do this cycle
        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_RX_PTR, S_RX_DAT: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        sreg_d    = {sreg_q[6:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b1;
                        state_d   = S_ACK_R;
                        if (state_q == S_ADDR) begin
                            if (sreg_q[7:1] == CHIP_ADDR) begin
                                state_d = S_ACK_A;
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = S_IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == S_RX_PTR) begin
                            ptr_d = sreg_q[AW-1:0];
                        end else begin
                            mem_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sreg_q;
                            ptr_d     = ptr_q + AW'(1);
                        end
                    end
                end
                S_ACK_A: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (sreg_q[0]) begin
                            state_d  = S_TX;
                            txb_d    = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = S_RX_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_ACK_R: begin
                    if (scl_fall) begin
                        state_d  = S_RX_DAT;
                        sda_oe_d = 1'b0;
                    end
                end
                S_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            state_d   = S_RX_ACK;
                            ptr_d     = ptr_q + AW'(1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            txb_d     = {txb_q[6:0], 1'b0};
                            sda_oe_d  = ~txb_q[6];
                        end
                    end
                end
                S_RX_ACK: begin
                    // A fall here means the master acked on the preceding rise
                    if (scl_rise && sda_c) begin
                        state_d = S_IDLE;
                    end else if (scl_fall) begin
                        state_d  = S_TX;
                        txb_d    = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            sreg_q    <= 8'd0;
            txb_q     <= 8'd0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
        end else begin
            scl_p_q   <= scl_c;
            sda_p_q   <= sda_c;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            txb_q     <= txb_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && mem_we) begin
            mem[ptr_q] <= sreg_q;
        end
    end

    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-banged I2C master, vector table and write-strobe scoreboard.
module tb_i2c_slave_mem;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    wire        sda;
    logic       busy, wr_stb;
    logic [7:0] wr_addr, wr_data;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_mem #(.CHIP_ADDR(7'h18), .DEPTH(256)) dut (
        .clk(clk), .resetn(resetn), .scl(scl), .sda(sda),
        .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    wr_t  sb_e;
    logic watch = 1'b0;
    logic low_seen = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_stb_unexpected: got addr=%h data=%h required none", wr_addr, wr_data);
            end else begin
                sb_e = exp_q.pop_front();
                chk("wr_stb", {wr_addr, wr_data}, sb_e);
            end
        end
        if (watch && !m_oe && sda === 1'b0) low_seen <= 1'b1;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s);
        wclk(2);
        m_oe = ~b;
        wclk(8);
        scl = 1'b1;
        wclk(4);
        s = sda;
        wclk(4);
        scl = 1'b0;
    endtask

    task automatic start_c();
        wclk(2);
        m_oe = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        m_oe = 1'b1;
        wclk(8);
        scl = 1'b0;
    endtask

    task automatic stop_c();
        wclk(2);
        m_oe = 1'b1;
        wclk(8);
        scl = 1'b1;
        wclk(8);
        m_oe = 1'b0;
        wclk(8);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(nack, s);
    endtask

    task automatic write2(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1);
        logic [3:0] a;
        start_c();
        wbyte(8'h30, a[3]);
        wbyte(ptr, a[2]);
        exp_q.push_back({ptr, d0});
        wbyte(d0, a[1]);
        exp_q.push_back({8'(ptr + 8'd1), d1});
        wbyte(d1, a[0]);
        stop_c();
        chk("write_acks", {12'd0, a}, 16'h0000);
        chk("write_sb_drained", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic read2(input logic [7:0] ptr, output logic [7:0] r0, output logic [7:0] r1);
        logic [2:0] a;
        start_c();
        wbyte(8'h30, a[2]);
        wbyte(ptr, a[1]);
        start_c();
        wbyte(8'h31, a[0]);
        rbyte(1'b0, r0);
        rbyte(1'b1, r1);
        wclk(6);
        chk("nack_release", {15'd0, sda}, 16'd1);
        chk("busy_after_nack", {15'd0, busy}, 16'd1);
        stop_c();
        chk("read_acks", {13'd0, a}, 16'h0000);
        chk("busy_after_stop", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] r0, r1, pr, d0, d1;
        logic [2:0] a;
        logic       s;
        logic [7:0] rb;

        tbl[0] = '{ptr: 8'h10, d0: 8'hA5, d1: 8'h5A};
        tbl[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22};
        tbl[2] = '{ptr: 8'h00, d0: 8'h00, d1: 8'hFF};
        tbl[3] = '{ptr: 8'h7F, d0: 8'h80, d1: 8'h01};
        tbl[4] = '{ptr: 8'hAA, d0: 8'h55, d1: 8'hAA};

        wclk(4);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wr_stb", {15'd0, wr_stb}, 16'd0);
        chk("rst_wr", {wr_addr, wr_data}, 16'h0000);
        chk("rst_sda", {15'd0, sda}, 16'd1);
        resetn = 1'b1;
        wclk(6);

        // Single write with busy tracking
        start_c();
        wbyte(8'h30, a[2]);
        chk("busy_addressed", {15'd0, busy}, 16'd1);
        wbyte(8'h10, a[1]);
        exp_q.push_back({8'h10, 8'hA5});
        wbyte(8'hA5, a[0]);
        stop_c();
        chk("single_write_acks", {13'd0, a}, 16'h0000);
        chk("single_write_busy", {15'd0, busy}, 16'd0);
        chk("single_write_sb", 16'(exp_q.size()), 16'd0);

        // Address mismatch: no ACK, no strobe, bus never pulled low by the target
        watch = 1'b1;
        start_c();
        wbyte(8'h32, a[1]);
        chk("mismatch_busy", {15'd0, busy}, 16'd0);
        wbyte(8'h10, a[0]);
        stop_c();
        watch = 1'b0;
        chk("mismatch_acks", {14'd0, a[1:0]}, 16'h0003);
        chk("mismatch_sda_low", {15'd0, low_seen}, 16'd0);
        chk("mismatch_busy_end", {15'd0, busy}, 16'd0);

        for (int i = 0; i < 5; i++) begin
            write2(tbl[i].ptr, tbl[i].d0, tbl[i].d1);
            read2(tbl[i].ptr, r0, r1);
            chk("tbl_rd0", {tbl[i].ptr, r0}, {tbl[i].ptr, tbl[i].d0});
            chk("tbl_rd1", {tbl[i].ptr, r1}, {tbl[i].ptr, tbl[i].d1});
        end

        // Reset during the 4th bit of a data byte
        write2(8'h40, 8'h3C, 8'h4D);
        start_c();
        wbyte(8'h30, a[1]);
        wbyte(8'h40, a[0]);
        rb = 8'hD5;
        for (int i = 7; i > 4; i--) send_bit(rb[i], s);
        wclk(2);
        m_oe = ~rb[4];
        wclk(3);
        resetn = 1'b0;
        wclk(1);
        chk("midrst_sda", {15'd0, sda}, 16'd1);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_wr_stb", {15'd0, wr_stb}, 16'd0);
        wclk(1);
        resetn = 1'b1;
        wclk(5);
        scl = 1'b1;
        wclk(8);
        scl = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(rb[i], s);
        send_bit(1'b1, s);
        stop_c();
        read2(8'h40, r0, r1);
        chk("midrst_keep0", {8'h40, r0}, {8'h40, 8'h3C});
        chk("midrst_keep1", {8'h41, r1}, {8'h41, 8'h4D});

        for (int i = 0; i < 10; i++) begin
            pr = 8'($urandom_range(0, 255));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            write2(pr, d0, d1);
            read2(pr, r0, r1);
            chk("rand_rd0", {pr, r0}, {pr, d0});
            chk("rand_rd1", {pr, r1}, {pr, d1});
        end

        wclk(4);
        chk("sb_final", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
